gray_step_decoder: RTL and testbench

- Receiving end of the team's 2-bit T-flip-flop Gray sequencer; the sequencer advances 00→10→11→01→00 while x=0 and holds while x=1.
- Samples the observed state {A,B} and recovers the x stream.
- Tracks a binary phase and step count, and flags transitions the sequencer cannot produce.
- Sits between the sequencer outputs and downstream monitor/counter logic.

---
 rtl/gray_step_decoder_pkg.sv | 36 +++
 rtl/gray_step_decoder_phase_map.sv | 28 ++
 rtl/gray_step_decoder.sv | 156 +++++++++++++++
 tb/tb_gray_step_decoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gray_step_decoder_pkg.sv
// ============================================================================
// Module      : gray_step_decoder_pkg
// Description : Shared FSM encoding, Gray phase map and step-delta codes for
//               the Gray step decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_step_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Sequencer state {A,B} observed at each phase of the forward cycle
    localparam logic [1:0] GRAY_P0 = 2'b00;
    localparam logic [1:0] GRAY_P1 = 2'b10;
    localparam logic [1:0] GRAY_P2 = 2'b11;
    localparam logic [1:0] GRAY_P3 = 2'b01;

    localparam logic [1:0] D_HOLD = 2'd0;
    localparam logic [1:0] D_FWD  = 2'd1;
    localparam logic [1:0] D_SKIP = 2'd2;
    localparam logic [1:0] D_REV  = 2'd3;

    // Phase distance modulo 4; the 2-bit result wraps naturally
    function automatic logic [1:0] phase_delta(input logic [1:0] phase_new,
                                               input logic [1:0] phase_prev);
        return phase_new - phase_prev;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_step_decoder_phase_map.sv
// ============================================================================
// Module      : gray_phase_map
// Description : Combinational map from sequencer Gray state to binary phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_phase_map
    import gray_step_decoder_pkg::*;
(
    input  logic [1:0] gray,
    output logic [1:0] phase
);

    always_comb begin
        phase = 2'd0;
        case (gray)
            GRAY_P0: phase = 2'd0;
            GRAY_P1: phase = 2'd1;
            GRAY_P2: phase = 2'd2;
            GRAY_P3: phase = 2'd3;
            default: phase = 2'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gray_step_decoder.sv
// ============================================================================
// Module      : gray_step_decoder
// Description : Recovers the x stream of the 2-bit Gray sequencer, tracks its
//               phase and step count, and flags impossible transitions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_step_decoder
    import gray_step_decoder_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       state_in,
    output logic             x_rec,
    output logic             valid,
    output logic             step_pulse,
    output logic [1:0]       pos,
    output logic [CNT_W-1:0] step_cnt,
    output logic             locked,
    output logic             err_rev,
    output logic             err_skip
);

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_prev, w_prev_nxt;
    logic [1:0]         w_phase_new;
    logic [1:0]         w_delta;

    logic               r_x_rec, w_x_rec_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_step_pulse, w_step_pulse_nxt;
    logic [1:0]         r_pos, w_pos_nxt;
    logic [CNT_W-1:0]   r_step_cnt, w_step_cnt_nxt;
    logic               r_locked, w_locked_nxt;
    logic               r_err_rev, w_err_rev_nxt;
    logic               r_err_skip, w_err_skip_nxt;

    gray_phase_map u_phase_in (
        .gray  (state_in),
        .phase (w_phase_new)
    );

    assign w_delta = phase_delta(w_phase_new, r_prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_prev       <= 2'd0;
            r_x_rec      <= 1'b0;
            r_valid      <= 1'b0;
            r_step_pulse <= 1'b0;
            r_pos        <= 2'd0;
            r_step_cnt   <= '0;
            r_locked     <= 1'b0;
            r_err_rev    <= 1'b0;
            r_err_skip   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= w_prev_nxt;
            r_x_rec      <= w_x_rec_nxt;
            r_valid      <= w_valid_nxt;
            r_step_pulse <= w_step_pulse_nxt;
            r_pos        <= w_pos_nxt;
            r_step_cnt   <= w_step_cnt_nxt;
            r_locked     <= w_locked_nxt;
            r_err_rev    <= w_err_rev_nxt;
            r_err_skip   <= w_err_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_prev_nxt       = r_prev;
        w_x_rec_nxt      = r_x_rec;
        w_valid_nxt      = 1'b0;
        w_step_pulse_nxt = 1'b0;
        w_pos_nxt        = r_pos;
        w_step_cnt_nxt   = r_step_cnt;
        w_locked_nxt     = r_locked;
        w_err_rev_nxt    = r_err_rev;
        w_err_skip_nxt   = r_err_skip;

        // Clear wins over a coincident sample, which is simply dropped
        if (clr) begin
            w_state_nxt    = ST_IDLE;
            w_step_cnt_nxt = '0;
            w_err_rev_nxt  = 1'b0;
            w_err_skip_nxt = 1'b0;
            w_locked_nxt   = 1'b0;
            w_x_rec_nxt    = 1'b0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    w_prev_nxt   = w_phase_new;
                    w_pos_nxt    = w_phase_new;
                    w_locked_nxt = 1'b1;
                    w_valid_nxt  = 1'b1;
                    w_x_rec_nxt  = 1'b1;
                    w_state_nxt  = ST_TRACK;
                end
                ST_TRACK: begin
                    w_valid_nxt = 1'b1;
                    case (w_delta)
                        D_HOLD: begin
                            w_x_rec_nxt = 1'b1;
                        end
                        D_FWD: begin
                            w_x_rec_nxt      = 1'b0;
                            w_step_pulse_nxt = 1'b1;
                            w_step_cnt_nxt   = r_step_cnt + CNT_W'(1);
                            w_pos_nxt        = w_phase_new;
                            w_prev_nxt       = w_phase_new;
                        end
                        D_REV: begin
                            w_x_rec_nxt   = 1'b0;
                            w_err_rev_nxt = 1'b1;
                            w_locked_nxt  = 1'b0;
                            w_state_nxt   = ST_FAULT;
                        end
                        D_SKIP: begin
                            w_x_rec_nxt    = 1'b0;
                            w_err_skip_nxt = 1'b1;
                            w_locked_nxt   = 1'b0;
                            w_state_nxt    = ST_FAULT;
                        end
                        default: ;
                    endcase
                end
                ST_FAULT: begin
                    w_locked_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign x_rec      = r_x_rec;
    assign valid      = r_valid;
    assign step_pulse = r_step_pulse;
    assign pos        = r_pos;
    assign step_cnt   = r_step_cnt;
    assign locked     = r_locked;
    assign err_rev    = r_err_rev;
    assign err_skip   = r_err_skip;

endmodule

`default_nettype wire

// File: tb/tb_gray_step_decoder.sv
// ============================================================================
// Module      : tb_gray_step_decoder
// Description : Directed self-checking bench for gray_step_decoder (CNT_W=8
//               and a CNT_W=3 copy sharing the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_step_decoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] state_in;

    logic       x_rec, valid, step_pulse, locked, err_rev, err_skip;
    logic [1:0] pos;
    logic [7:0] step_cnt;

    logic       s_x_rec, s_valid, s_step_pulse, s_locked, s_err_rev, s_err_skip;
    logic [1:0] s_pos;
    logic [2:0] s_step_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    gray_step_decoder #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .state_in   (state_in),
        .x_rec      (x_rec),
        .valid      (valid),
        .step_pulse (step_pulse),
        .pos        (pos),
        .step_cnt   (step_cnt),
        .locked     (locked),
        .err_rev    (err_rev),
        .err_skip   (err_skip)
    );

    gray_step_decoder #(.CNT_W(3)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .state_in   (state_in),
        .x_rec      (s_x_rec),
        .valid      (s_valid),
        .step_pulse (s_step_pulse),
        .pos        (s_pos),
        .step_cnt   (s_step_cnt),
        .locked     (s_locked),
        .err_rev    (s_err_rev),
        .err_skip   (s_err_skip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic x, input logic v, input logic sp,
                              input logic [1:0] p, input int cnt, input logic lk,
                              input logic er, input logic es);
        logic [2:0] cnt3;
        cnt3 = cnt[2:0];
        check({tag, ".x_rec"},      x_rec,      x);
        check({tag, ".valid"},      valid,      v);
        check({tag, ".step_pulse"}, step_pulse, sp);
        check({tag, ".pos"},        pos,        p);
        check({tag, ".step_cnt"},   step_cnt,   cnt[7:0]);
        check({tag, ".locked"},     locked,     lk);
        check({tag, ".err_rev"},    err_rev,    er);
        check({tag, ".err_skip"},   err_skip,   es);
        check({tag, ".cnt3"},       s_step_cnt, cnt3);
        check({tag, ".lock3"},      s_locked,   lk);
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge
    task automatic cyc(input logic e, input logic c, input logic [1:0] st);
        @(negedge clk);
        en       = e;
        clr      = c;
        state_in = st;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] gray_of [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; state_in = 2'b00;
        #12;
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        cyc(0, 1, 2'b00);
        expect_out("clr0", 0, 0, 0, 0, 0, 0, 0, 0);

        // Full forward cycle
        cyc(1, 0, 2'b00); expect_out("fwd0", 1, 1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 2'b10); expect_out("fwd1", 0, 1, 1, 1, 1, 1, 0, 0);
        cyc(1, 0, 2'b11); expect_out("fwd2", 0, 1, 1, 2, 2, 1, 0, 0);
        cyc(1, 0, 2'b01); expect_out("fwd3", 0, 1, 1, 3, 3, 1, 0, 0);
        cyc(1, 0, 2'b00); expect_out("fwd4", 0, 1, 1, 0, 4, 1, 0, 0);
        cyc(0, 0, 2'b11); expect_out("idle_en0", 0, 0, 0, 0, 4, 1, 0, 0);

        // Hold recovery
        cyc(0, 1, 2'b00); expect_out("hold_clr", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b00); expect_out("hold0", 1, 1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 2'b10); expect_out("hold1", 0, 1, 1, 1, 1, 1, 0, 0);
        cyc(1, 0, 2'b10); expect_out("hold2", 1, 1, 0, 1, 1, 1, 0, 0);
        cyc(1, 0, 2'b10); expect_out("hold3", 1, 1, 0, 1, 1, 1, 0, 0);
        cyc(1, 0, 2'b11); expect_out("hold4", 0, 1, 1, 2, 2, 1, 0, 0);

        // Reverse fault
        cyc(0, 1, 2'b00); expect_out("rev_clr", 0, 0, 0, 2, 0, 0, 0, 0);
        cyc(1, 0, 2'b11); expect_out("rev_lock", 1, 1, 0, 2, 0, 1, 0, 0);
        cyc(1, 0, 2'b10); expect_out("rev_hit", 0, 1, 0, 2, 0, 0, 1, 0);
        cyc(1, 0, 2'b11); expect_out("rev_frozen", 0, 0, 0, 2, 0, 0, 1, 0);
        cyc(1, 0, 2'b01); expect_out("rev_frozen2", 0, 0, 0, 2, 0, 0, 1, 0);
        cyc(0, 1, 2'b00); expect_out("rev_clr2", 0, 0, 0, 2, 0, 0, 0, 0);
        cyc(1, 0, 2'b00); expect_out("rev_relock", 1, 1, 0, 0, 0, 1, 0, 0);

        // Skip fault
        cyc(0, 1, 2'b00); expect_out("skip_clr", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b00); expect_out("skip_lock", 1, 1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 2'b11); expect_out("skip_hit", 0, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 2'b10); expect_out("skip_frozen", 0, 0, 0, 0, 0, 0, 0, 1);

        // Counter wrap on the 3-bit copy
        cyc(0, 1, 2'b00); expect_out("wrap_clr", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b00); expect_out("wrap_lock", 1, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 0, gray_of[i % 4]);
            expect_out($sformatf("wrap%0d", i), 0, 1, 1, 2'(i % 4), i, 1, 0, 0);
        end

        // Asynchronous reset mid-stream
        cyc(0, 1, 2'b00);
        cyc(1, 0, 2'b00);
        for (int i = 1; i <= 5; i++) cyc(1, 0, gray_of[i % 4]);
        expect_out("ar_pre", 0, 1, 1, 1, 5, 1, 0, 0);
        @(negedge clk);
        en = 1'b0; clr = 1'b0;
        #1 rst = 1'b0;
        #1 expect_out("ar_async", 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        cyc(1, 0, 2'b00); expect_out("ar_relock", 1, 1, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 2'b10); expect_out("ar_clr_en", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b10); expect_out("ar_idle_lock", 1, 1, 0, 1, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
